mul_issue_ctrl: RTL

Issue/retire controller for the 3-stage pipelined dadda-tree multiplier in the M-extension unit. It accepts MUL/MULH/MULHSU/MULHU requests from EX with a valid/ready handshake and presents operands and mode to the free-running multiplier. It tracks each operation's tag through the fixed pipeline latency, applies MULHSU sign correction, and selects the result half. Results are buffered in an output FIFO so that writeback backpressure never loses a product.

---
 rtl/mul_issue_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - Issue/retire controller for the pipelined M-extension multiplier
//
// Accepts MUL/MULH/MULHSU/MULHU requests, drives the free-running multiplier,
// tracks tags through its fixed latency, applies MULHSU sign correction,
// selects the result half and buffers results in a credit-managed FIFO.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    kill all in-flight and buffered operations
//   req_valid/req_ready      request handshake from EX
//   req_funct3               000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
//   req_rs1, req_rs2         operands
//   req_tag                  destination tag
//   mul_rs1_data/rs2_data    multiplier operands (0 when nothing is issued)
//   mul_funct3               multiplier mode, 000 unsigned, otherwise signed
//   mul_out                  multiplier product, LATENCY cycles after issue
//   rsp_valid/rsp_ready      result FIFO head handshake
//   rsp_data, rsp_tag        result and its tag (0 while the FIFO is empty)
//   busy                     any operation in flight or buffered
module mul_issue_ctrl #(
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      mul_rs1_data,
    output logic [31:0]      mul_rs2_data,
    output logic [2:0]       mul_funct3,
    input  logic [63:0]      mul_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(LATENCY + FIFO_DEPTH + 1);
    localparam int LAST  = LATENCY - 1;

    // Accept-cycle decode
    logic               accept;
    logic               acc_hi;
    logic               acc_neg;

    // Tracking pipeline: entry i describes the operation issued i+1 cycles ago,
    // so entry LAST lines up with its product on mul_out.
    logic [LATENCY-1:0] trk_valid;
    logic [LATENCY-1:0] trk_hi;
    logic [LATENCY-1:0] trk_neg;
    logic [TAG_W-1:0]   trk_tag [LATENCY];

    // Result FIFO
    logic [31:0]        mem_data [FIFO_DEPTH];
    logic [TAG_W-1:0]   mem_tag  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic [63:0]        prod;
    logic [31:0]        push_data;

    // Credit: every operation already issued (in flight or buffered) holds a
    // FIFO slot, so the FIFO can never be asked to take more than it holds.
    logic [OCC_W-1:0]   occ;

    always_comb begin
        occ = OCC_W'(count);
        for (int i = 0; i < LATENCY; i++) begin
            occ = occ + OCC_W'(trk_valid[i]);
        end
    end

    assign req_ready = !rst && !flush && (occ < OCC_W'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;

    // Operand mapping. MULHSU runs as an unsigned multiply of |rs1| by rs2
    // and the product sign is restored at capture time.
    always_comb begin
        mul_rs1_data = '0;
        mul_rs2_data = '0;
        mul_funct3   = 3'b000;
        acc_hi       = 1'b0;
        acc_neg      = 1'b0;
        if (accept) begin
            mul_rs1_data = req_rs1;
            mul_rs2_data = req_rs2;
            case (req_funct3)
                3'b000: begin
                end
                3'b001: begin
                    mul_funct3 = 3'b001;
                    acc_hi     = 1'b1;
                end
                3'b010: begin
                    acc_hi  = 1'b1;
                    acc_neg = req_rs1[31];
                    if (req_rs1[31]) begin
                        mul_rs1_data = -req_rs1;
                    end
                end
                default: begin
                    acc_hi = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            trk_valid <= '0;
        end else begin
            trk_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                trk_valid[i] <= trk_valid[i-1];
            end
        end
        // Payload shifts unconditionally; only the valid bits matter.
        trk_tag[0] <= req_tag;
        trk_hi[0]  <= acc_hi;
        trk_neg[0] <= acc_neg;
        for (int i = 1; i < LATENCY; i++) begin
            trk_tag[i] <= trk_tag[i-1];
            trk_hi[i]  <= trk_hi[i-1];
            trk_neg[i] <= trk_neg[i-1];
        end
    end

    // Capture the product aligned with the last tracking entry
    assign prod      = trk_neg[LAST] ? -mul_out : mul_out;
    assign push_data = trk_hi[LAST] ? prod[63:32] : prod[31:0];
    assign push      = trk_valid[LAST];
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Empty without disturbing the write side; a capture coinciding
            // with the flush belongs to a killed operation and is dropped.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_tag[wr_ptr]  <= trk_tag[LAST];
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rsp_valid = (count != '0);
    // Head is forced to zero when empty so stale entries never show.
    assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : '0;
    assign rsp_tag   = rsp_valid ? mem_tag[rd_ptr]  : '0;
    assign busy      = (|trk_valid) || rsp_valid;

endmodule
